countdown_timer: RTL and testbench

Programmable periodic tick generator. A down-counter loads a run-time reload value and decrements on each enabled clock. When the count reaches zero, the block emits a one-clock `Pulse` and reloads. It sits beside the system clock (50 MHz) and provides slow timebase ticks, such as a 0.8 s tick from reload 40_000_000−1, to the rest of the design.

---
 rtl/countdown_timer_pkg.sv | 15 +
 rtl/down_counter.sv | 42 ++++
 rtl/countdown_timer.sv | 45 ++++
 tb/tb_countdown_timer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown_timer tick generator: default counter
// width, system clock frequency and ready-made reload values.
package countdown_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // System clock feeding the timer.
  localparam int unsigned CLK_HZ = 50_000_000;

  // Reload values are one less than the desired period in clock cycles.
  localparam int unsigned RELOAD_0P8S = 40_000_000 - 1;
  localparam int unsigned RELOAD_1S   = CLK_HZ - 1;
  localparam int unsigned RELOAD_1MS  = (CLK_HZ / 1_000) - 1;

endpackage : countdown_timer_pkg

// File: rtl/down_counter.sv
// Loadable, enabled WIDTH-bit decrementer with a zero flag.
// Reaching zero while enabled reloads instead of decrementing, so the
// counter never wraps. The o_count port exists only when
// COUNTDOWN_TIMER_COUNT_OUT_EN is defined.
module down_counter
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_zero
`ifdef COUNTDOWN_TIMER_COUNT_OUT_EN
  ,
  output logic [WIDTH-1:0] o_count
`endif
);

  logic [WIDTH-1:0] r_cnt;

  // Load on reset or on an enabled zero, otherwise step down when enabled.
  // NOTE: reset is synchronous, so it lives inside the clocked branch rather
  // than in the sensitivity list; non-blocking assignments keep every flop
  // sampling pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= i_load_value;
    end else if (i_en) begin
      if (o_zero) r_cnt <= i_load_value;
      else        r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

`ifdef COUNTDOWN_TIMER_COUNT_OUT_EN
  assign o_count = r_cnt;
`endif

endmodule : down_counter

// File: rtl/countdown_timer.sv
// Programmable periodic tick generator. Pulse is a registered one-cycle
// tick every InitValue+1 enabled cycles. Define COUNTDOWN_TIMER_COUNT_OUT_EN
// to expose the live counter value on Count.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] InitValue,
  output logic             Pulse
`ifdef COUNTDOWN_TIMER_COUNT_OUT_EN
  ,
  output logic [WIDTH-1:0] Count
`endif
);

  logic w_zero;
  logic r_pulse;

  down_counter #(
    .WIDTH(WIDTH)
  ) u_down_counter (
    .i_clk        (Clock),
    .i_rst_n      (Reset),
    .i_en         (Enable),
    .i_load_value (InitValue),
    .o_zero       (w_zero)
`ifdef COUNTDOWN_TIMER_COUNT_OUT_EN
    ,
    .o_count      (Count)
`endif
  );

  // Tick on the same edge the counter reloads; reset cancels a pending tick.
  always_ff @(posedge Clock) begin
    if (!Reset) r_pulse <= 1'b0;
    else        r_pulse <= Enable && w_zero;
  end

  assign Pulse = r_pulse;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer. Count checks are active
// when COUNTDOWN_TIMER_COUNT_OUT_EN is defined.
module tb_countdown_timer;

  localparam int unsigned WIDTH = 32;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             Enable;
  logic [WIDTH-1:0] InitValue;
  logic             Pulse;
`ifdef COUNTDOWN_TIMER_COUNT_OUT_EN
  logic [WIDTH-1:0] Count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  countdown_timer #(
    .WIDTH(WIDTH)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Enable    (Enable),
    .InitValue (InitValue),
    .Pulse     (Pulse)
`ifdef COUNTDOWN_TIMER_COUNT_OUT_EN
    ,
    .Count     (Count)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input logic [WIDTH-1:0] exp);
`ifdef COUNTDOWN_TIMER_COUNT_OUT_EN
    check(tag, Count, exp);
`endif
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic hold_reset(input int n);
    Reset = 1'b0;
    repeat (n) tick();
    Reset = 1'b1;
  endtask

  initial begin
    int exp_c3[9];
    exp_c3 = '{4, 3, 2, 2, 2, 2, 1, 0, 5};

    // Period 40: reset held 10 cycles, pulses at edges 40, 80, 120.
    Enable    = 1'b1;
    InitValue = 39;
    hold_reset(10);
    check("t1_reset_pulse", Pulse, 0);
    check_count("t1_reset_count", 39);
    for (int k = 1; k <= 120; k++) begin
      tick();
      check($sformatf("t1_pulse_e%0d", k), Pulse, (k % 40 == 0) ? 1 : 0);
      if (k == 1)   check_count("t1_count_e1", 38);
      if (k == 39)  check_count("t1_count_e39", 0);
      if (k == 40)  check_count("t1_count_reload", 39);
    end

    // InitValue 0: tick on every enabled cycle after the first edge.
    InitValue = 0;
    hold_reset(2);
    check("t2_reset_pulse", Pulse, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t2_pulse_e%0d", k), Pulse, 1);
      check_count($sformatf("t2_count_e%0d", k), 0);
    end

    // Period 6 with Enable low for edges 4..6: pulse slips from edge 6 to 9.
    InitValue = 5;
    hold_reset(2);
    for (int k = 1; k <= 9; k++) begin
      Enable = (k >= 4 && k <= 6) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("t3_pulse_e%0d", k), Pulse, (k == 9) ? 1 : 0);
      check_count($sformatf("t3_count_e%0d", k), exp_c3[k-1]);
    end
    Enable = 1'b1;

    // Reload changed 9 -> 3 mid-period: pulses at edges 10, 14, 18.
    InitValue = 9;
    hold_reset(2);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 2) InitValue = 3;
      check($sformatf("t4_pulse_e%0d", k), Pulse,
            (k == 10 || k == 14 || k == 18) ? 1 : 0);
    end

    // Reset while cnt = 1: no pulse, full period restarts from 5.
    InitValue = 5;
    hold_reset(2);
    repeat (4) tick();
    check_count("t5_count_before", 1);
    hold_reset(1);
    check("t5_reset_pulse", Pulse, 0);
    check_count("t5_reset_count", 5);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t5_pulse_e%0d", k), Pulse, (k == 6) ? 1 : 0);
    end

    // Enable low from reset: never ticks, count parked at InitValue.
    Enable    = 1'b0;
    InitValue = 7;
    hold_reset(2);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("t6_pulse_e%0d", k), Pulse, 0);
    end
    check_count("t6_count", 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_countdown_timer
